// File: rtl/dmem_lsu_seq.sv
// rtl/dmem_lsu_seq.sv - RV32I load/store sequencer in front of the data_mem cache (optional DMEM_LSU_TIMEOUT_EN)
module dmem_lsu_seq #(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ALIGN    = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;

  // Last guard count: stall is first sampled GUARD_CYCLES cycles after the strobe.
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  // Reject out-of-range parameters at elaboration.
  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
      TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("dmem_lsu_seq: GUARD_CYCLES or TIMEOUT_CYCLES out of range");
  end

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_wdata_q;
  logic        req_store_q;
  logic [2:0]  req_funct3_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_mask_q;
  logic [3:0]  guard_q, guard_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic        accept, load_mem;
  logic        illegal, misaligned;
  logic [3:0]  mask_dec;

`ifdef DMEM_LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  logic [7:0] tmo_q, tmo_d;
`endif

  assign req_ready      = (state_q == S_IDLE) && !mem_clk_stall;
  assign accept         = req_valid && req_ready;
  assign mem_memwrite   = (state_q == S_ISSUE) &&  req_store_q;
  assign mem_memread    = (state_q == S_ISSUE) && !req_store_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_sign_mask  = mem_mask_q;
  assign rsp_valid      = (state_q == S_DONE);
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

  // Decode funct3 of the held request into sign_mask, legality and alignment.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    mask_dec   = 4'b0000;
    case (req_funct3_q)
      3'b000: mask_dec = {~req_store_q, 3'b001};
      3'b001: begin
        mask_dec   = {~req_store_q, 3'b011};
        misaligned = req_addr_q[0];
      end
      3'b010: begin
        mask_dec   = 4'b0111;
        misaligned = |req_addr_q[1:0];
      end
      3'b100: begin
        mask_dec = 4'b0001;
        illegal  = req_store_q;
      end
      3'b101: begin
        mask_dec   = 4'b0011;
        misaligned = req_addr_q[0];
        illegal    = req_store_q;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Next-state logic: sequence CHECK/ISSUE/WAIT/DONE and build the response.
  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    load_mem    = 1'b0;
`ifdef DMEM_LSU_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CHECK;
      end
      S_CHECK: begin
        guard_d = 4'd0;
`ifdef DMEM_LSU_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
        if (illegal) begin
          state_d     = S_DONE;
          rsp_err_d   = ERR_FUNCT3;
          rsp_rdata_d = 32'd0;
        end else if (misaligned) begin
          state_d     = S_DONE;
          rsp_err_d   = ERR_ALIGN;
          rsp_rdata_d = 32'd0;
        end else begin
          state_d  = S_ISSUE;
          load_mem = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (guard_q != GUARD_LAST) guard_d = guard_q + 4'd1;
        if (guard_q == GUARD_LAST && !mem_clk_stall) begin
          state_d     = S_DONE;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = req_store_q ? 32'd0 : mem_read_data;
        end
`ifdef DMEM_LSU_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d     = S_DONE;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = 32'd0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      S_DONE: begin
        state_d     = S_IDLE;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = ERR_OK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture and held data_mem request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_addr_q   <= 32'd0;
      req_wdata_q  <= 32'd0;
      req_store_q  <= 1'b0;
      req_funct3_q <= 3'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_mask_q   <= 4'd0;
      guard_q      <= 4'd0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        req_addr_q   <= req_addr;
        req_wdata_q  <= req_wdata;
        req_store_q  <= req_store;
        req_funct3_q <= req_funct3;
      end
      if (load_mem) begin
        mem_addr_q  <= req_addr_q;
        mem_wdata_q <= req_wdata_q;
        mem_mask_q  <= mask_dec;
      end
    end
  end

`ifdef DMEM_LSU_TIMEOUT_EN
  // WAIT-state cycle budget.
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= 8'd0;
    else       tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_dmem_lsu_seq.sv
// tb/tb_dmem_lsu_seq.sv - directed self-checking bench for dmem_lsu_seq
module tb_dmem_lsu_seq;

  localparam int G = 2;
`ifdef DMEM_LSU_TIMEOUT_EN
  localparam int TMO = 16;
  localparam int TMO_LAT = 3 + TMO;
`else
  localparam int TMO = 255;
  localparam int TMO_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'd0;
  logic        mem_clk_stall = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_lsu_seq #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; the bench plays data_mem, raising clk_stall G cycles after
  // the strobe for stall_n cycles. exp_lat=0 means no response is expected.
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] model, input int stall_n,
                        input logic [3:0] exp_mask, input logic [1:0] exp_err,
                        input logic [31:0] exp_rdata, input int exp_lat);
    int wr_n = 0;
    int rd_n = 0;
    int strobe_c = 0;
    int rsp_c = 0;
    int bad_hold = 0;
    int ready_n = 0;
    logic [31:0] got_rdata = 32'd0;
    logic [1:0]  got_err = 2'd0;
    logic strobed;
    strobed = (exp_err == 2'b00) || (exp_err == 2'b11);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; mem_read_data = model; mem_clk_stall = 1'b0;
    check({tag, "/ready_idle"}, {31'd0, req_ready}, 32'd1);
    for (int c = 1; c <= 40 && rsp_c == 0; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_memwrite) begin wr_n++; strobe_c = c; end
      if (mem_memread)  begin rd_n++; strobe_c = c; end
      if (strobe_c != 0 && (mem_addr !== addr || mem_write_data !== wd ||
                            mem_sign_mask !== exp_mask)) bad_hold++;
      mem_clk_stall = (strobe_c != 0 && c >= strobe_c + G && c < strobe_c + G + stall_n);
      #1;
      if (req_ready) ready_n++;
      if (rsp_valid) begin rsp_c = c; got_rdata = rsp_rdata; got_err = rsp_err; end
    end
    mem_clk_stall = 1'b0;
    check({tag, "/memwrite_cycles"}, wr_n, (strobed && st) ? 1 : 0);
    check({tag, "/memread_cycles"}, rd_n, (strobed && !st) ? 1 : 0);
    if (strobed) begin
      check({tag, "/strobe_cycle"}, strobe_c, 2);
      check({tag, "/held_addr_data_mask"}, bad_hold, 0);
    end
    check({tag, "/ready_busy"}, ready_n, 0);
    check({tag, "/latency"}, rsp_c, exp_lat);
    if (exp_lat != 0) begin
      check({tag, "/rsp_err"}, {30'd0, got_err}, {30'd0, exp_err});
      check({tag, "/rsp_rdata"}, got_rdata, exp_rdata);
      @(posedge clk); #1;
      check({tag, "/rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset/req_ready", {31'd0, req_ready}, 32'd1);
    check("reset/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset/strobes", {30'd0, mem_memwrite, mem_memread}, 32'd0);
    check("reset/mem_addr", mem_addr, 32'd0);
    check("reset/mem_write_data", mem_write_data, 32'd0);
    check("reset/sign_mask", {28'd0, mem_sign_mask}, 32'd0);
    check("reset/rsp_err", {30'd0, rsp_err}, 32'd0);
    check("reset/rsp_rdata", rsp_rdata, 32'd0);

    //     tag    st    f3      addr          wdata         model         stall mask     err    rdata         lat
    do_req("SB",  1'b1, 3'b000, 32'h400, 32'h0000_0AAA, 32'h1234_5678, 2, 4'b0001, 2'b00, 32'h0,        3 + G + 2);
    do_req("LB",  1'b0, 3'b000, 32'h400, 32'h0,         32'hFFFF_FFAA, 0, 4'b1001, 2'b00, 32'hFFFF_FFAA, 3 + G);
    do_req("LBU", 1'b0, 3'b100, 32'h400, 32'h0,         32'h0000_00AA, 0, 4'b0001, 2'b00, 32'h0000_00AA, 3 + G);
    do_req("SH",  1'b1, 3'b001, 32'h100, 32'h0002_AAAA, 32'h5555_5555, 1, 4'b0011, 2'b00, 32'h0,        3 + G + 1);
    do_req("LH",  1'b0, 3'b001, 32'h100, 32'h0,         32'hFFFF_AAAA, 0, 4'b1011, 2'b00, 32'hFFFF_AAAA, 3 + G);
    do_req("LHU_mis", 1'b0, 3'b101, 32'h101, 32'h0,     32'hDEAD_BEEF, 0, 4'b0000, 2'b01, 32'h0,        2);
    do_req("SW",  1'b1, 3'b010, 32'h40,  32'hAAAA_AAAA, 32'h0,         5, 4'b0111, 2'b00, 32'h0,        3 + G + 5);
    do_req("LW",  1'b0, 3'b010, 32'h40,  32'h0,         32'hAAAA_AAAA, 5, 4'b0111, 2'b00, 32'hAAAA_AAAA, 3 + G + 5);
    do_req("SW_mis", 1'b1, 3'b010, 32'h42, 32'h1,       32'h0,         0, 4'b0000, 2'b01, 32'h0,        2);
    do_req("L011", 1'b0, 3'b011, 32'h40, 32'h0,         32'hCAFE_F00D, 0, 4'b0000, 2'b10, 32'h0,        2);
    do_req("S100", 1'b1, 3'b100, 32'h40, 32'h12,        32'h0,         0, 4'b0000, 2'b10, 32'h0,        2);

    // Reset while WAITing on a stalled load.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstwait/memread_issue", {31'd0, mem_memread}, 32'd1);
    @(posedge clk); #1 mem_clk_stall = 1'b1; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rstwait/strobes", {30'd0, mem_memwrite, mem_memread}, 32'd0);
    check("rstwait/mem_addr", mem_addr, 32'd0);
    check("rstwait/sign_mask", {28'd0, mem_sign_mask}, 32'd0);
    check("rstwait/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstwait/ready_stalled", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstwait/ready_hold", {31'd0, req_ready}, 32'd0);
    end
    mem_clk_stall = 1'b0; #1;
    check("rstwait/ready_release", {31'd0, req_ready}, 32'd1);

    // Stall never released: timeout response or no response at all.
    do_req("TMO", 1'b0, 3'b010, 32'h40, 32'h0, 32'h7777_7777, 1000, 4'b0111, 2'b11, 32'h0, TMO_LAT);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    #1 check("final/req_ready", {31'd0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_seq.md
Name: dmem_lsu_seq

Overview:
- Load/store sequencer between the pipeline MEM stage and the data_mem cache; sits directly upstream of data_mem and drives its addr/write_data/memwrite/memread/sign_mask inputs.
- Accepts one decoded RV32I load/store and checks alignment.
- Issues a single-cycle strobe to data_mem, holds the request stable while data_mem asserts clk_stall, then returns a one-cycle response.

Parameters:
- GUARD_CYCLES, 2: cycles after the strobe during which mem_clk_stall is ignored, covering the cache's stall-rise latency; legal range 1..15.
- TIMEOUT_CYCLES, 255: cycle budget in WAIT before forced abort; used only with DMEM_LSU_TIMEOUT_EN; legal range 16..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  sequencer can accept
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- mem_addr  out  32  to data_mem addr
- mem_write_data  out  32  to data_mem write_data
- mem_memwrite  out  1  to data_mem memwrite
- mem_memread  out  1  to data_mem memread
- mem_sign_mask  out  4  to data_mem sign_mask
- mem_read_data  in  32  from data_mem read_data (already extended by data_mem)
- mem_clk_stall  in  1  from data_mem clk_stall
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0 (mem_addr, mem_write_data, mem_sign_mask, strobes, rsp_*); counters 0.
- Reset mid-operation: on the next edge, strobes drop and state returns to IDLE. The cache transaction is not cancelled.
- req_ready = (state==IDLE) & !mem_clk_stall. After a reset during an access, no new request is accepted until data_mem releases the stall.
- Accept: on req_valid & req_ready, register addr, wdata, store and funct3.
- sign_mask decode:
  - 000 -> 0001 (B), 001 -> 0011 (H), 010 -> 0111 (W).
  - 100 -> 0001 (BU), 101 -> 0011 (HU).
  - Bit 3 = sign-extend; set only for loads with funct3 000/001. Stores always use bit3=0.
  - funct3 010 with req_store=0 gives 0111; LW takes no sign bit.
  - Other funct3 values, and stores with funct3 1xx, are illegal.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- FSM states: IDLE, CHECK, ISSUE, WAIT, DONE.
  - IDLE -> CHECK on accept.
  - CHECK (1 cycle): if illegal or misaligned -> DONE with rsp_err set; no strobe is ever driven. Otherwise -> ISSUE.
  - ISSUE (1 cycle): mem_memwrite=req_store and mem_memread=!req_store for exactly this cycle. mem_addr, mem_write_data and mem_sign_mask are driven from ISSUE until leaving WAIT and held stable throughout.
  - WAIT: strobes low; guard counter counts to GUARD_CYCLES. After the guard, the first cycle with mem_clk_stall=0 -> DONE, capturing mem_read_data for loads.
  - DONE (1 cycle): rsp_valid=1 with rsp_rdata/rsp_err valid -> IDLE. There is no response backpressure.
- Latency: ok access = 3 + GUARD_CYCLES + stall cycles from accept to rsp_valid. Error response = rsp_valid 2 cycles after accept.
- mem_* outputs keep their last values in IDLE; only the strobes are guaranteed 0.

Optional Feature:
- DMEM_LSU_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT. When it reaches TIMEOUT_CYCLES -> DONE with rsp_err=11 and rsp_rdata=0.
  - req_ready still waits for mem_clk_stall=0.
- DMEM_LSU_TIMEOUT_EN not defined: the counter logic is absent, WAIT waits indefinitely, and rsp_err=11 is never produced.

Test Plan:
- SB: addr=0x400, wdata=0xAAA, funct3 000 -> one-cycle mem_memwrite, mem_sign_mask=0001, mem_addr=0x400 held through the stall; rsp_valid with rsp_err=00.
- LB then LBU at 0x400: model returns 0xFFFFFFAA, then 0x000000AA -> mem_sign_mask 1001 then 0001; rsp_rdata equals the model value on each; exactly one mem_memread cycle each.
- SH at 0x100 with 0x2AAAA, then LH at 0x100 -> sign_mask 0011, then 1011; LHU at 0x101 -> rsp_err=01 two cycles after accept, with no strobe.
- SW/LW at 0x40, 0xAAAAAAAA, with clk_stall held for 5 cycles -> rsp_valid exactly 3+GUARD_CYCLES+5 cycles after accept; req_ready=0 throughout.
- funct3 011 load -> rsp_err=10, no strobe. Reset asserted in WAIT -> outputs zero the next cycle; req_ready stays 0 until the model drops clk_stall.
- With DMEM_LSU_TIMEOUT_EN, stall held forever and TIMEOUT_CYCLES=16 -> rsp_err=11 after 16 WAIT cycles. Without the macro, no response is produced.
